// File: rtl/fpga_ddr3_dmaster_channel_arbiter_pkg.sv
// Shared dmaster arbitration types and round-robin search helper; purely combinational content.
// No latency or backpressure of its own; users add registers and flow control around it.
package fpga_ddr3_dmaster_pkg;

    localparam int RR_MAX_IN = 16;
    localparam int RR_IDX_W  = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Search wraps modulo 16; callers zero unused request bits so this equals wrap modulo NUM_IN.
    function automatic logic [RR_IDX_W-1:0] rr_select(input logic [RR_MAX_IN-1:0] valid,
                                                      input logic [RR_IDX_W-1:0]  ptr);
        logic [RR_IDX_W-1:0] idx;
        logic [RR_IDX_W-1:0] cand;
        logic                found;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_IN; k++) begin
            cand = ptr + RR_IDX_W'(k);
            if (!found && valid[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fpga_ddr3_dmaster_channel_arbiter_if.sv
// Requester-side and output-side Avalon-ST signals of the dmaster channel arbiter.
// master = arbiter side, slave = requesters plus downstream sink.
interface fpga_ddr3_dmaster_channel_arbiter_if #(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_startofpacket;
    logic [NUM_IN-1:0]        in_endofpacket;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CHANNEL_W-1:0]     out_channel;
    logic                     out_startofpacket;
    logic                     out_endofpacket;
    logic                     protocol_error;

    modport master (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_channel, out_startofpacket,
               out_endofpacket, protocol_error
    );

    modport slave (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_channel, out_startofpacket,
               out_endofpacket, protocol_error
    );
endinterface

// File: rtl/fpga_ddr3_dmaster_channel_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping; zero latency.
// No backpressure; any=0 means idx is meaningless.
module fpga_ddr3_dmaster_rr_pick
    import fpga_ddr3_dmaster_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);
    logic [RR_MAX_IN-1:0] req_ext;
    logic [RR_IDX_W-1:0]  ptr_ext;
    logic [RR_IDX_W-1:0]  sel;

    assign req_ext = RR_MAX_IN'(req);
    assign ptr_ext = RR_IDX_W'(ptr);
    assign sel     = rr_select(req_ext, ptr_ext);
    assign idx     = sel[IDX_W-1:0];
    assign any     = |req;
endmodule

// File: rtl/fpga_ddr3_dmaster_channel_arbiter.sv
// Packet-locked round-robin arbiter onto one registered Avalon-ST byte stream; 1 cycle grant, 1 cycle data.
// Backpressure: granted in_ready = !out_valid || out_ready; output payload holds while out_ready is low.
module fpga_ddr3_dmaster_channel_arbiter
    import fpga_ddr3_dmaster_pkg::*;
#(
    parameter  int NUM_IN    = 4,
    parameter  int DATA_W    = 8,
    parameter  int CHANNEL_W = 8,
    localparam int IDX_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic clk,
    input  logic reset,
    fpga_ddr3_dmaster_channel_arbiter_if.master bus
);
    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                out_vld_q;
    logic [DATA_W-1:0]   out_dat_q;
    logic [IDX_W-1:0]    out_chan_q;
    logic                out_sop_q;
    logic                out_eop_q;
    logic                first_q;
    logic                perr_q;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                sel_vld;
    logic [DATA_W-1:0]   sel_dat;
    logic                sel_sop;
    logic                sel_eop;
    logic                grant_rdy;
    logic                accept;
    logic [NUM_IN-1:0]   in_rdy;

    fpga_ddr3_dmaster_rr_pick #(.NUM_IN(NUM_IN)) u_rr_pick (
        .req (bus.in_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_vld = 1'b0;
        sel_dat = '0;
        sel_sop = 1'b0;
        sel_eop = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_vld = bus.in_valid[i];
                sel_dat = bus.in_data[i*DATA_W +: DATA_W];
                sel_sop = bus.in_startofpacket[i];
                sel_eop = bus.in_endofpacket[i];
            end
        end
    end

    assign grant_rdy = (state_q == ST_LOCKED) && (!out_vld_q || bus.out_ready);
    assign accept    = grant_rdy && sel_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_LOCKED;
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == IDX_W'(NUM_IN - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_LOCKED: begin
                // No timeout: an idle granted requester holds the lock until its EOP.
                if (accept && sel_eop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_rdy = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q == IDX_W'(i)) begin
                in_rdy[i] = grant_rdy;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_chan_q <= '0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
        end else if (accept) begin
            out_vld_q  <= 1'b1;
            out_dat_q  <= sel_dat;
            out_chan_q <= grant_q;
            out_sop_q  <= sel_sop;
            out_eop_q  <= sel_eop;
        end else if (bus.out_ready) begin
            out_vld_q  <= 1'b0;
        end
    end

    // first_q marks that the next accepted beat is the opening beat of the locked packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && pick_any) begin
                first_q <= 1'b1;
            end else if (accept) begin
                first_q <= 1'b0;
            end
            if (accept && first_q && !sel_sop) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready          = in_rdy;
    assign bus.out_valid         = out_vld_q;
    assign bus.out_data          = out_dat_q;
    assign bus.out_channel       = CHANNEL_W'(out_chan_q);
    assign bus.out_startofpacket = out_sop_q;
    assign bus.out_endofpacket   = out_eop_q;
    assign bus.protocol_error    = perr_q;
endmodule

// File: doc/fpga_ddr3_dmaster_channel_arbiter.md
# fpga_ddr3_dmaster_channel_arbiter

Packet-aware round-robin arbiter that shares the DMA master's single Avalon-ST byte stream among NUM_IN requesting channels. Each requester presents an 8-bit Avalon-ST packet stream. The block grants one requester for a whole packet (SOP through EOP) and forwards its beats through a registered output stage, tagging each beat with the granted index on `out_channel`. It sits upstream of the channel adapter, whose maximum channel is 0, so only channel-0 traffic reaches the bytes-to-packets path; non-zero channels are for ports that support them.

## Interface
Parameters:
- NUM_IN, 4: number of requesters; legal range 2–16.
- DATA_W, 8: beat width in bits.
- CHANNEL_W, 8: width of `out_channel`; must satisfy 2^CHANNEL_W ≥ NUM_IN.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_IN  per-requester valid.
- in_ready  out  NUM_IN  per-requester ready; at most one bit is set.
- in_data  in  NUM_IN*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- in_startofpacket  in  NUM_IN  per-requester SOP.
- in_endofpacket  in  NUM_IN  per-requester EOP.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  forwarded beat.
- out_channel  out  CHANNEL_W  index of the requester that produced the beat, zero-extended.
- out_startofpacket  out  1  forwarded SOP.
- out_endofpacket  out  1  forwarded EOP.
- protocol_error  out  1  sticky; set on a mid-packet beat arriving while unlocked. Cleared only by reset.

## Operation
- **FSM states:** IDLE and LOCKED, plus `grant` (index register) and `rr_ptr` (highest-priority index).
- **IDLE:**
  - If any `in_valid` bit is set, select the first valid index at or after `rr_ptr`, searching upward with wrap-around.
  - Register the selected index in `grant`, set `rr_ptr` to (selected+1) mod NUM_IN, and go to LOCKED.
  - `in_ready` is all-zero in IDLE.
- **LOCKED:**
  - `in_ready[grant]` = !out_valid || out_ready. All other `in_ready` bits are 0.
  - A beat is accepted when `in_valid[grant]` and `in_ready[grant]` are both high. On acceptance, the output register loads data, SOP, EOP and channel (= `grant`).
  - An accepted beat with EOP returns the FSM to IDLE on the same edge.
  - The FSM stays LOCKED indefinitely while the granted requester is idle mid-packet. There is no timeout and no preemption.
- **Output register:**
  - `out_valid` sets on acceptance.
  - It clears when `out_ready` is high and no new beat is accepted in the same cycle.
  - A simultaneous drain and accept keeps `out_valid` high with the new payload.
- **Protocol check:**
  - The first beat accepted after entering LOCKED must carry SOP. If it does not, set `protocol_error` and forward the beat unchanged.
  - An SOP on a later beat within the same packet is forwarded and not flagged.
- **Reset:** resets asynchronously mid-packet with no flush. Any beat held in the output register is discarded.

## Timing
- **Reset values:**
  - Outputs: out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0, in_ready=0, protocol_error=0.
  - Internal: FSM=IDLE, grant=0, rr_ptr=0.
- **Arbitration latency:** a request seen in IDLE at edge N gives `in_ready` high in cycle N+1. The first accept happens at edge N+1 at the earliest.
- **Data latency:** a beat accepted at edge K appears on `out_*` in cycle K+1.
- **Throughput:** one beat per cycle while LOCKED and `out_ready` is held high.
- **Packet gap:** at least one idle cycle on the input side between packets, for arbitration.
- **Single-beat packets (SOP and EOP set):** lock for exactly one accept.
- **out_ready low:** `out_valid` and the payload hold stable. `in_ready[grant]` is low while out_valid=1 and out_ready=0.
- **Request withdrawn:** a requester dropping `in_valid` in the cycle after it was granted still holds the grant.

## Structure
- Shared package `fpga_ddr3_dmaster_pkg` holds:
  - the FSM state encoding (ST_IDLE, ST_LOCKED);
  - the helper function `rr_select(valid, ptr)`, which returns the first set index at or after `ptr`.
- One sub-module: `fpga_ddr3_dmaster_rr_pick`. It is combinational and parameterised by NUM_IN, with inputs `req` and `ptr` and outputs `idx` and `any`. It is reusable by other dmaster arbiters.

## Test plan
- **Single requester:** reset; requester 2 sends a 4-beat packet 0xA0..0xA3 with out_ready=1. Required: in_ready[2] rises 1 cycle after the request; out beats 0xA0..0xA3 with out_channel=2, SOP on the first beat, EOP on the last; FSM returns to IDLE.
- **Round robin, all requesting:** all 4 requesters continuously send 2-beat packets. Required: grant order 0,1,2,3,0; no interleaving of beats between packets.
- **Backpressure:** out_ready toggles 1,0,0,1 during a 3-beat packet. Required: out_data holds while out_ready=0; no beat lost or duplicated; in_ready[grant] is low when out_valid=1 and out_ready=0.
- **Single-beat packets:** requesters 1 and 3 each send SOP+EOP beats 0x11 and 0x33. Required: out sequence 0x11 (channel 1), then 0x33 (channel 3), each beat carrying both SOP and EOP.
- **Missing SOP:** requester 0 sends a first beat without SOP. Required: the beat is forwarded and protocol_error=1, remaining 1 through later error-free packets until reset.
- **Reset mid-packet:** assert reset after 2 of 5 beats. Required: all outputs are 0 immediately; after release, requester 0 is granted first with rr_ptr=0.
